// File: rtl/riscv_mem.sv
// Unified instruction/data word memory with registered read, write-through,
// sticky misalignment flag and a byte-serial loader that fills words from index 0.
module riscv_mem #(
    parameter int unsigned byte_addr_p = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [byte_addr_p-1:0] addr_i,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   err_o,
    input  logic                   load_mode_i,
    input  logic                   load_start_i,
    input  logic                   load_valid_i,
    input  logic [7:0]             load_data_i,
    output logic                   load_ready_o,
    output logic [byte_addr_p-2:0] load_count_o
);
    localparam int unsigned IW    = byte_addr_p - 2;
    localparam int unsigned CW    = byte_addr_p - 1;
    localparam int unsigned DEPTH = 1 << IW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ASSEMBLE, COMMIT, FULL} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [31:0]   asm_q, asm_d;
    logic [31:0]   data_d;
    logic          err_d;
    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] widx;
    logic          accept, core_wr, commit_wr;

    assign widx         = addr_i[byte_addr_p-1:2];
    assign load_ready_o = (state_q == ASSEMBLE) && load_mode_i && !load_start_i;
    assign accept       = load_ready_o && load_valid_i;
    assign core_wr      = !load_mode_i && wr_en_i && !rst_i;
    assign commit_wr    = (state_q == COMMIT) && !load_start_i && !rst_i;
    assign load_count_o = cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        case (state_q)
            IDLE: begin
                if (load_mode_i) state_d = (cnt_q == FULL_CNT) ? FULL : ASSEMBLE;
            end
            ASSEMBLE: begin
                if (!load_mode_i) begin
                    state_d = IDLE;
                    bidx_d  = '0;
                end else if (accept) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = load_data_i;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) state_d = COMMIT;
                end
            end
            COMMIT: begin
                ptr_d  = ptr_q + IW'(1);
                cnt_d  = cnt_q + CW'(1);
                bidx_d = '0;
                if (cnt_q + CW'(1) == FULL_CNT) state_d = FULL;
                else if (load_mode_i)           state_d = ASSEMBLE;
                else                            state_d = IDLE;
            end
            FULL: begin
                if (!load_mode_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load_start_i) begin
            state_d = IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            bidx_d  = '0;
        end
    end

    // Core port is frozen (data_o and err_o hold) while the loader owns the array.
    always_comb begin
        data_d = data_o;
        err_d  = err_o;
        if (!load_mode_i) begin
            data_d = wr_en_i ? data_i : mem[widx];
            if ((rd_en_i || wr_en_i) && (addr_i[1:0] != 2'b00)) err_d = 1'b1;
        end
        if (load_start_i) err_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            data_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            data_o  <= data_d;
            err_o   <= err_d;
        end
    end

    // Array has no reset; a core write lands after a same-cycle commit so it wins a collision.
    always_ff @(posedge clk_i) begin
        if (commit_wr) mem[ptr_q] <= asm_q;
        if (core_wr)   mem[widx]  <= data_i;
    end
endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for riscv_mem: a 12-bit instance for core/loader behaviour and a
// 4-word instance for the full boundary.
module tb_riscv_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic        wr, rd, mode, start, valid, ready, err;
    logic [31:0] din, dout;
    logic [7:0]  ldata;
    logic [10:0] count;

    logic [3:0]  s_addr;
    logic        s_wr, s_rd, s_mode, s_start, s_valid, s_ready, s_err;
    logic [31:0] s_din, s_dout;
    logic [7:0]  s_ldata;
    logic [2:0]  s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_mem #(.byte_addr_p(12)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_en_i(wr), .rd_en_i(rd),
        .data_i(din), .data_o(dout), .err_o(err), .load_mode_i(mode),
        .load_start_i(start), .load_valid_i(valid), .load_data_i(ldata),
        .load_ready_o(ready), .load_count_o(count)
    );

    riscv_mem #(.byte_addr_p(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .addr_i(s_addr), .wr_en_i(s_wr), .rd_en_i(s_rd),
        .data_i(s_din), .data_o(s_dout), .err_o(s_err), .load_mode_i(s_mode),
        .load_start_i(s_start), .load_valid_i(s_valid), .load_data_i(s_ldata),
        .load_ready_o(s_ready), .load_count_o(s_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        bit ok = 1'b0;
        if (sel) begin s_valid = 1'b1; s_ldata = b; end
        else     begin valid   = 1'b1; ldata   = b; end
        for (int i = 0; i < 10; i++) begin
            if ((sel ? s_ready : ready) === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL send_byte timeout: ready=0 required=1"); end
        tick();
        if (sel) s_valid = 1'b0; else valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 12'h000; rd = 1'b1; wr = 1'b0; din = '0;
        mode = 1'b0; start = 1'b0; valid = 1'b0; ldata = '0;
        s_addr = '0; s_wr = 1'b0; s_rd = 1'b0; s_din = '0;
        s_mode = 1'b0; s_start = 1'b0; s_valid = 1'b0; s_ldata = '0;
        #2;
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", dout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (count !== 11'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (s_count !== 3'd0) begin bad++; $display("FAIL reset_s_count: got %0d want 0", s_count); end
        tick(); tick();
        rst = 1'b0;
        addr = 12'h020; wr = 1'b1; din = 32'h11223344;
        tick();
        wr = 1'b0; din = '0;
        tick();
        total++; if (dout !== 32'h11223344) begin bad++; $display("FAIL post_reset_read: got %h want 11223344", dout); end
    endtask

    task automatic test_load();
        logic [7:0] bytes [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
        tick(); tick();
        total++; if (count !== 11'd2) begin bad++; $display("FAIL load_count: got %0d want 2", count); end
        mode = 1'b0; addr = 12'h000; rd = 1'b1;
        tick();
        total++; if (dout !== 32'h00100513) begin bad++; $display("FAIL load_word0: got %h want 00100513", dout); end
        addr = 12'h004;
        tick();
        total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word1: got %h want deadbeef", dout); end
    endtask

    task automatic test_core_write();
        addr = 12'h010; wr = 1'b1; din = 32'hCAFEF00D;
        tick();
        total++; if (dout !== 32'hCAFEF00D) begin bad++; $display("FAIL write_through: got %h want cafef00d", dout); end
        wr = 1'b0; din = '0;
        tick();
        total++; if (dout !== 32'hCAFEF00D) begin bad++; $display("FAIL write_readback: got %h want cafef00d", dout); end
        addr = 12'h000;
        tick();
        total++; if (dout !== 32'h00100513) begin bad++; $display("FAIL write_other_word: got %h want 00100513", dout); end
    endtask

    task automatic test_misalign();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err); end
        addr = 12'h006; rd = 1'b1;
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
        total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL misalign_trunc: got %h want deadbeef", dout); end
        addr = 12'h010;
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
        total++; if (dout !== 32'hCAFEF00D) begin bad++; $display("FAIL sticky_read: got %h want cafef00d", dout); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
        total++; if (count !== 11'd0) begin bad++; $display("FAIL start_count: got %0d want 0", count); end
    endtask

    task automatic test_abort_and_start();
        mode = 1'b1;
        send_byte(1'b0, 8'hAA);
        send_byte(1'b0, 8'hBB);
        mode = 1'b0; addr = 12'h000; rd = 1'b1;
        tick(); tick();
        total++; if (count !== 11'd0) begin bad++; $display("FAIL abort_count: got %0d want 0", count); end
        total++; if (dout !== 32'h00100513) begin bad++; $display("FAIL abort_word: got %h want 00100513", dout); end
        mode = 1'b1;
        tick(); tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL assemble_ready: got %b want 1", ready); end
        start = 1'b1; valid = 1'b1; ldata = 8'h77;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL start_blocks_ready: got %b want 0", ready); end
        tick();
        start = 1'b0; valid = 1'b0;
        total++; if (count !== 11'd0) begin bad++; $display("FAIL start_priority_count: got %0d want 0", count); end
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h03);
        send_byte(1'b0, 8'h04);
        tick();
        total++; if (count !== 11'd1) begin bad++; $display("FAIL reload_count: got %0d want 1", count); end
        mode = 1'b0; addr = 12'h000;
        tick();
        total++; if (dout !== 32'h04030201) begin bad++; $display("FAIL reload_word0: got %h want 04030201", dout); end
    endtask

    task automatic test_full();
        int accepted = 0;
        s_start = 1'b1; s_mode = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(i));
        total++; if (s_count !== 3'd3) begin bad++; $display("FAIL full_pre_commit: got %0d want 3", s_count); end
        tick();
        total++; if (s_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", s_count); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", s_ready); end
        s_valid = 1'b1; s_ldata = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            if (s_ready === 1'b1) accepted++;
            tick();
        end
        s_valid = 1'b0;
        total++; if (accepted != 0) begin bad++; $display("FAIL full_extra_bytes: got %0d want 0", accepted); end
        total++; if (s_count !== 3'd4) begin bad++; $display("FAIL full_count_hold: got %0d want 4", s_count); end
        s_mode = 1'b0;
        tick();
        s_mode = 1'b1;
        tick(); tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_reenter: got %b want 0", s_ready); end
        total++; if (s_count !== 3'd4) begin bad++; $display("FAIL full_reenter_count: got %0d want 4", s_count); end
        s_mode = 1'b0; s_addr = 4'h0; s_rd = 1'b1;
        tick();
        total++; if (s_dout !== 32'h03020100) begin bad++; $display("FAIL full_word0: got %h want 03020100", s_dout); end
        s_addr = 4'hC;
        tick();
        total++; if (s_dout !== 32'h0F0E0D0C) begin bad++; $display("FAIL full_word3: got %h want 0f0e0d0c", s_dout); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_core_write();
        test_misalign();
        test_abort_and_start();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/riscv_mem.md
# riscv_mem

Single-port unified instruction/data memory. It is the responder on the core control FSM's memory interface: the core drives a byte address plus read/write strobes, and this block returns the addressed word one clock later. A byte-serial loader port fills the memory from word 0 upward before the core runs. Misaligned core accesses are flagged with a sticky error.

## Interface
- byte_addr_p, 12, byte-address width; depth = 2^(byte_addr_p-2) 32-bit words
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- addr_i  in  byte_addr_p  core byte address; bits [1:0] are ignored for indexing
- wr_en_i  in  1  core word-write strobe
- rd_en_i  in  1  core read qualifier; used only for misalignment checking
- data_i  in  32  core write data
- data_o  out  32  registered read data
- err_o  out  1  sticky misaligned-access flag
- load_mode_i  in  1  loader owns the memory while high
- load_start_i  in  1  one-cycle pulse; restarts the load at word 0
- load_valid_i  in  1  loader byte valid
- load_data_i  in  8  loader byte, little-endian within each word
- load_ready_o  out  1  loader may present a byte
- load_count_o  out  byte_addr_p-1  number of words committed since the last load_start_i

## Operation
- Array: depth x 32 bits. The array is not cleared by reset. Word index = addr_i[byte_addr_p-1:2].
- Core port is active only while load_mode_i = 0:
  - Every cycle, data_o is updated from the indexed word. rd_en_i is not needed to read, because the core fetches with only the address driven.
  - When wr_en_i = 1, data_i is written to the indexed word, and data_o shows data_i in the same update (write-through).
  - If (rd_en_i | wr_en_i) and addr_i[1:0] != 0: err_o is set, and the access still completes on the truncated index.
- Core port while load_mode_i = 1: wr_en_i is ignored, data_o holds its value, err_o is not updated.
- Loader FSM, states IDLE, ASSEMBLE, COMMIT, FULL:
  - IDLE: if load_mode_i = 1, go to FULL when load_count_o = depth, otherwise go to ASSEMBLE.
  - ASSEMBLE: load_ready_o = 1 (only if load_mode_i = 1 and load_start_i = 0).
    - A byte is accepted when load_valid_i & load_ready_o, and lands in byte lane byte_idx (0..3).
    - Accepting lane 3 moves to COMMIT.
    - load_mode_i = 0 moves to IDLE, discards the partial word and sets byte_idx to 0; the pointer is kept.
  - COMMIT: load_ready_o = 0. The assembled word is written at the pointer, then pointer++, load_count_o++ and byte_idx = 0. Next state: FULL if the new count = depth; else ASSEMBLE if load_mode_i = 1; else IDLE.
  - FULL: load_ready_o = 0; no bytes are accepted. load_mode_i = 0 moves to IDLE, and the count is kept.
- load_start_i, in any state, takes priority:
  - Next state is IDLE; pointer, load_count_o, byte_idx and err_o are cleared.
  - No byte is accepted in that cycle (load_ready_o is forced to 0 combinationally).
- The pointer has byte_addr_p-2 bits and cannot wrap, because FULL blocks any further loading.

## Timing
- Reset values: data_o = 0, err_o = 0, load_ready_o = 0, load_count_o = 0, FSM = IDLE, pointer = 0, byte_idx = 0.
- Read latency is 1 cycle: addr_i sampled at edge N appears on data_o after edge N. This matches the core's FETCH_FIRST/FETCH_SECOND and MEM_RD_FIRST/MEM_RD_SECOND wait states.
- A core write takes effect at the sampling edge. A read of the same word on the next cycle returns the new data.
- load_ready_o is combinational from FSM state, load_mode_i and load_start_i.
- Throughput: 4 accepted bytes plus 1 COMMIT cycle = one word every 5 cycles at best. load_count_o is updated at the COMMIT edge.
- load_mode_i rising: ASSEMBLE is entered one cycle later, so the earliest byte acceptance is the 2nd cycle.
- If rst_i is asserted mid-load, all state is cleared immediately. Array contents written so far are kept, but load_count_o reads 0.

## Test plan
- Reset then core access: rst_i pulse, then read addr 0x000 with rd_en_i = 1 -> data_o = 0 during reset; afterwards data_o equals the array word one cycle after the address is presented.
- Load and read back: load_start_i, load_mode_i = 1, stream bytes 0x13,0x05,0x10,0x00,0xEF,0xBE,0xAD,0xDE -> load_count_o = 2. With load_mode_i = 0, reading 0x000 returns 0x00100513 and reading 0x004 returns 0xDEADBEEF, each one cycle after the address.
- Core write and read: wr_en_i at 0x010 with data_i = 0xCAFEF00D -> data_o = 0xCAFEF00D next cycle; a read of 0x010 the cycle after returns the same value.
- Misalignment: rd_en_i at 0x006 -> err_o = 1 and stays 1 through later aligned accesses; load_start_i clears it to 0.
- Partial abort and start priority: send 2 bytes, then drop load_mode_i -> word not written, load_count_o unchanged. Assert load_start_i together with load_valid_i -> no byte accepted, load_count_o = 0.
- Full boundary: byte_addr_p = 4 (4 words), stream 20 bytes -> load_count_o = 4 after the 16th byte, FSM in FULL, load_ready_o = 0, and the last 4 bytes are never accepted.
